// File: rtl/rename_pkg.sv
// Shared types and sizing for the dispatch-side rename controller.
// Table entry layout: bit 6 pending, bits 5:0 producer tag.
package rename_pkg;

  localparam int TAG_W        = 6;
  localparam int ADDR_W       = 5;
  localparam int NUM_TAGS     = 63;
  localparam int RST_ENTRY_W  = 7;
  localparam int RST_PEND_BIT = 6;
  localparam int POOL_DEPTH   = 64;
  localparam int CNT_W        = 7;
  localparam int NUM_REGS     = 32;

  typedef enum logic {
    INIT,
    RUN
  } rn_state_e;

  typedef struct packed {
    logic             pend;
    logic [TAG_W-1:0] tag;
  } rst_entry_t;

endpackage

// File: rtl/tag_free_list.sv
// Circular pool of free rename tags.
// Head is read combinationally; an init port fills it during INIT.
module tag_free_list
  import rename_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             init_wen,
  input  logic [TAG_W-1:0] init_addr,
  input  logic [TAG_W-1:0] init_data,
  input  logic             push,
  input  logic [TAG_W-1:0] push_tag,
  input  logic             pop,
  output logic [TAG_W-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [TAG_W-1:0] mem [POOL_DEPTH];
  logic [TAG_W-1:0] rd_ptr;
  logic [TAG_W-1:0] wr_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign pop_ok  = pop && (count != '0);
  // a full pool can only take a tag when one leaves in the same cycle
  assign push_ok = push &&
                   (pop_ok || (count != CNT_W'(NUM_TAGS)));
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (init_wen) begin
      mem[init_addr] <= init_data;
    end else if (push_ok) begin
      mem[wr_ptr] <= push_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (load) begin
      rd_ptr <= '0;
      wr_ptr <= TAG_W'(NUM_TAGS);
      count  <= CNT_W'(NUM_TAGS);
    end else begin
      if (pop_ok) begin
        rd_ptr <= rd_ptr + TAG_W'(1);
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + TAG_W'(1);
      end
      count <= count + CNT_W'(push_ok)
                     - CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/reg_rename_ctrl.sv
// Rename controller: allocates tags, maintains the register status
// table, recycles tags on CDB and rebuilds everything after flush.
module reg_rename_ctrl
  import rename_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   dispatch_valid,
  output logic                   dispatch_ready,
  input  logic                   dispatch_rd_wen,
  input  logic [ADDR_W-1:0]      dispatch_rd_addr,
  input  logic [ADDR_W-1:0]      dispatch_rs_addr,
  input  logic [ADDR_W-1:0]      dispatch_rt_addr,
  output logic [TAG_W-1:0]       dispatch_tag,
  output logic                   rs_pending,
  output logic [TAG_W-1:0]       rs_tag,
  output logic                   rt_pending,
  output logic [TAG_W-1:0]       rt_tag,
  input  logic                   cdb_valid,
  input  logic [TAG_W-1:0]       cdb_tag,
  output logic [ADDR_W-1:0]      rst_rport0_addr,
  input  logic [RST_ENTRY_W-1:0] rst_rport0_data,
  output logic [ADDR_W-1:0]      rst_rport1_addr,
  input  logic [RST_ENTRY_W-1:0] rst_rport1_data,
  output logic [ADDR_W-1:0]      rst_wport0_addr,
  output logic [RST_ENTRY_W-1:0] rst_wport0_data,
  output logic                   rst_wport0_wen,
  output logic [ADDR_W-1:0]      rst_wport1_addr,
  output logic [RST_ENTRY_W-1:0] rst_wport1_data,
  output logic                   rst_wport1_wen,
  output logic [TAG_W-1:0]       rst_lookup_tag,
  input  logic                   rst_lookup_found,
  input  logic [ADDR_W-1:0]      rst_lookup_addr,
  output logic [CNT_W-1:0]       free_count
);

  rn_state_e        state_q;
  rn_state_e        state_d;
  logic [TAG_W-1:0] init_cnt_q;
  logic [TAG_W-1:0] init_cnt_d;

  logic             clr;
  logic             run;
  logic             init_wen;
  logic             init_clear;
  logic             load;
  logic             fire;
  logic             alloc;
  logic             cdb_live;
  logic             cdb_hit;
  logic [TAG_W-1:0] head;
  logic [CNT_W-1:0] count;
  rst_entry_t       rs_e;
  rst_entry_t       rt_e;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    unique case (state_q)
      INIT: begin
        init_cnt_d = init_cnt_q + TAG_W'(1);
        if (init_cnt_q == TAG_W'(NUM_TAGS - 1)) begin
          state_d    = RUN;
          init_cnt_d = '0;
        end
      end
      RUN:     ;
      default: ;
    endcase
  end

  assign clr        = rst || flush;
  assign run        = (state_q == RUN);
  assign init_wen   = (state_q == INIT) && !clr;
  assign init_clear = init_cnt_q < TAG_W'(NUM_REGS / 2);
  assign load       = init_wen &&
                      (init_cnt_q == TAG_W'(NUM_TAGS - 1));

  assign dispatch_ready = run && (count != '0);
  assign fire  = dispatch_valid && dispatch_ready && !clr;
  assign alloc = fire && dispatch_rd_wen &&
                 (dispatch_rd_addr != '0);
  assign dispatch_tag = alloc ? head : '0;

  assign cdb_live       = run && !clr && cdb_valid &&
                          (cdb_tag != '0);
  assign rst_lookup_tag = run ? cdb_tag : '0;
  // a same-cycle allocation to that register is the newer mapping
  assign cdb_hit = cdb_live && rst_lookup_found &&
                   !(alloc && (dispatch_rd_addr == rst_lookup_addr));

  assign rst_rport0_addr = dispatch_rs_addr;
  assign rst_rport1_addr = dispatch_rt_addr;
  assign rs_e = rst_entry_t'(rst_rport0_data);
  assign rt_e = rst_entry_t'(rst_rport1_data);

  assign rs_pending = run && rs_e.pend &&
                      !(cdb_valid && (cdb_tag == rs_e.tag));
  assign rs_tag     = run ? rs_e.tag : '0;
  assign rt_pending = run && rt_e.pend &&
                      !(cdb_valid && (cdb_tag == rt_e.tag));
  assign rt_tag     = run ? rt_e.tag : '0;

  always_comb begin
    rst_wport0_addr = '0;
    rst_wport0_data = '0;
    rst_wport0_wen  = 1'b0;
    rst_wport1_addr = '0;
    rst_wport1_data = '0;
    rst_wport1_wen  = 1'b0;
    unique case (1'b1)
      init_wen: begin
        rst_wport0_addr = {init_cnt_q[3:0], 1'b0};
        rst_wport0_wen  = init_clear;
        rst_wport1_addr = {init_cnt_q[3:0], 1'b1};
        rst_wport1_wen  = init_clear;
      end
      run: begin
        rst_wport0_addr = dispatch_rd_addr;
        rst_wport0_data = {1'b1, head};
        rst_wport0_wen  = alloc;
        rst_wport1_addr = rst_lookup_addr;
        rst_wport1_wen  = cdb_hit;
      end
      default: ;
    endcase
  end

  tag_free_list u_free_list (
    .clk       (clk),
    .clr       (clr),
    .load      (load),
    .init_wen  (init_wen),
    .init_addr (init_cnt_q),
    .init_data (init_cnt_q + TAG_W'(1)),
    .push      (cdb_live),
    .push_tag  (cdb_tag),
    .pop       (alloc),
    .head      (head),
    .count     (count)
  );

  assign free_count = count;

endmodule
